// File: rtl/inertial_pkg.sv
// Shared types and constants for the inertial sensor interface: FSM states,
// sensor configuration words and the read addresses polled on each interrupt.
package inertial_pkg;

  localparam int CMD_W = 16;

  typedef enum logic [3:0] {
    ST_INIT_WAIT,
    ST_CFG0,
    ST_CFG1,
    ST_CFG2,
    ST_CFG3,
    ST_IDLE,
    ST_RD_PL,
    ST_RD_PH,
    ST_RD_AL,
    ST_RD_AH
  } state_t;

  localparam logic [CMD_W-1:0] CFG_INT_EN = 16'h0D02;  // data-ready interrupt enable
  localparam logic [CMD_W-1:0] CFG_ACCEL  = 16'h1053;  // accel 208Hz, +/-2g
  localparam logic [CMD_W-1:0] CFG_GYRO   = 16'h1150;  // gyro 208Hz, 250dps
  localparam logic [CMD_W-1:0] CFG_ROUND  = 16'h1460;  // rounding enable

  localparam logic [6:0] ADDR_PTCH_L = 7'h22;
  localparam logic [6:0] ADDR_PTCH_H = 7'h23;
  localparam logic [6:0] ADDR_AZ_L   = 7'h2C;
  localparam logic [6:0] ADDR_AZ_H   = 7'h2D;

  function automatic logic [CMD_W-1:0] rd_cmd(input logic [6:0] addr);
    return {1'b1, addr, 8'h00};
  endfunction

  // Command word a state sends when it issues its transaction.
  function automatic logic [CMD_W-1:0] state_cmd(input state_t s);
    case (s)
      ST_CFG0:  return CFG_INT_EN;
      ST_CFG1:  return CFG_ACCEL;
      ST_CFG2:  return CFG_GYRO;
      ST_CFG3:  return CFG_ROUND;
      ST_RD_PL: return rd_cmd(ADDR_PTCH_L);
      ST_RD_PH: return rd_cmd(ADDR_PTCH_H);
      ST_RD_AL: return rd_cmd(ADDR_AZ_L);
      ST_RD_AH: return rd_cmd(ADDR_AZ_H);
      default:  return '0;
    endcase
  endfunction

endpackage

// File: rtl/spi_mnrch.sv
// SPI mode-3 master: one 16-bit full-duplex transaction per wrt, SCLK divided
// from clk by 2^SCLK_DIV_W, MSB first, done pulses as SS_n returns high.
module spi_mnrch
  import inertial_pkg::*;
#(
  parameter int SCLK_DIV_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wrt,
  input  logic [CMD_W-1:0] cmd,
  output logic             done,
  output logic [CMD_W-1:0] rd_data,
  output logic             SS_n,
  output logic             SCLK,
  output logic             MOSI,
  input  logic             MISO
);

  localparam int BIT_W = $clog2(CMD_W + 1);
  // Idle value keeps SCLK high and gives a quarter-period front porch.
  localparam logic [SCLK_DIV_W-1:0] DIV_IDLE = {2'b11, {(SCLK_DIV_W-2){1'b0}}};
  localparam logic [SCLK_DIV_W-1:0] DIV_RISE = {1'b0, {(SCLK_DIV_W-1){1'b1}}};
  localparam logic [SCLK_DIV_W-1:0] DIV_FALL = '1;
  localparam logic [BIT_W-1:0]      LAST_BIT = BIT_W'(CMD_W);

  logic                  busy_q, busy_d;
  logic                  ss_n_q, ss_n_d;
  logic                  done_q, done_d;
  logic                  miso_smpl_q, miso_smpl_d;
  logic [SCLK_DIV_W-1:0] div_q, div_d;
  logic [CMD_W-1:0]      shft_q, shft_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path leaves it unassigned
    // and no latch is inferred; done_d defaults low so it can only pulse.
    busy_d      = busy_q;
    ss_n_d      = ss_n_q;
    done_d      = 1'b0;
    miso_smpl_d = miso_smpl_q;
    div_d       = div_q;
    shft_d      = shft_q;
    bit_cnt_d   = bit_cnt_q;
    if (!busy_q) begin
      if (wrt) begin
        busy_d    = 1'b1;
        ss_n_d    = 1'b0;
        div_d     = DIV_IDLE;
        shft_d    = cmd;
        bit_cnt_d = '0;
      end
    end else begin
      div_d = div_q + SCLK_DIV_W'(1);
      if (div_q == DIV_RISE) begin
        miso_smpl_d = MISO;
        bit_cnt_d   = bit_cnt_q + BIT_W'(1);
      end else if (div_q == DIV_FALL && bit_cnt_q != '0) begin
        // The first fall has no sampled bit behind it, so nothing shifts.
        shft_d = {shft_q[CMD_W-2:0], miso_smpl_q};
        if (bit_cnt_q == LAST_BIT) begin
          busy_d = 1'b0;
          ss_n_d = 1'b1;
          done_d = 1'b1;
          div_d  = DIV_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    if (rst) begin
      busy_q      <= 1'b0;
      ss_n_q      <= 1'b1;
      done_q      <= 1'b0;
      miso_smpl_q <= 1'b0;
      div_q       <= DIV_IDLE;
      shft_q      <= '0;
      bit_cnt_q   <= '0;
    end else begin
      busy_q      <= busy_d;
      ss_n_q      <= ss_n_d;
      done_q      <= done_d;
      miso_smpl_q <= miso_smpl_d;
      div_q       <= div_d;
      shft_q      <= shft_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  assign done    = done_q;
  assign rd_data = shft_q;
  assign SS_n    = ss_n_q;
  assign SCLK    = div_q[SCLK_DIV_W-1];
  assign MOSI    = shft_q[CMD_W-1] & ~ss_n_q;

endmodule

// File: rtl/inertial_intf.sv
// Inertial sensor front end: configures the sensor after power-up, then on
// each data-ready interrupt reads pitch rate and Z accel and strobes vld.
module inertial_intf
  import inertial_pkg::*;
#(
  parameter int INIT_WAIT  = 65536,
  parameter int SCLK_DIV_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic        vld,
  output logic [15:0] ptch_rt,
  output logic [15:0] AZ
);

  localparam int TMR_W = (INIT_WAIT > 1) ? $clog2(INIT_WAIT) : 1;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             int_ff1_q, int_ff2_q, int_ff3_q;
  logic [7:0]       ptch_low_q, ptch_low_d;
  logic [7:0]       az_low_q, az_low_d;
  logic [15:0]      ptch_rt_q, ptch_rt_d;
  logic [15:0]      az_q, az_d;
  logic             vld_q, vld_d;
  logic             wrt_q, wrt_d;

  logic             done;
  logic [CMD_W-1:0] rd_data;
  logic             int_rise;
  logic             unused_rd_hi;

  assign int_rise     = int_ff2_q & ~int_ff3_q;
  assign unused_rd_hi = ^rd_data[CMD_W-1:8];  // response high byte carries no data

  spi_mnrch #(.SCLK_DIV_W(SCLK_DIV_W)) u_spi (
    .clk     (clk),
    .rst     (rst),
    .wrt     (wrt_q),
    .cmd     (state_cmd(state_q)),
    .done    (done),
    .rd_data (rd_data),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    ptch_low_d = ptch_low_q;
    az_low_d   = az_low_q;
    ptch_rt_d  = ptch_rt_q;
    az_d       = az_q;
    vld_d      = 1'b0;
    wrt_d      = 1'b0;
    case (state_q)
      ST_INIT_WAIT:
        if (tmr_q == TMR_W'(INIT_WAIT - 1)) begin
          state_d = ST_CFG0;
          wrt_d   = 1'b1;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      ST_CFG0: if (done) begin state_d = ST_CFG1; wrt_d = 1'b1; end
      ST_CFG1: if (done) begin state_d = ST_CFG2; wrt_d = 1'b1; end
      ST_CFG2: if (done) begin state_d = ST_CFG3; wrt_d = 1'b1; end
      ST_CFG3: if (done) state_d = ST_IDLE;
      // Interrupt edges outside IDLE are dropped, never queued.
      ST_IDLE: if (int_rise) begin state_d = ST_RD_PL; wrt_d = 1'b1; end
      ST_RD_PL:
        if (done) begin
          ptch_low_d = rd_data[7:0];
          state_d    = ST_RD_PH;
          wrt_d      = 1'b1;
        end
      ST_RD_PH:
        if (done) begin
          ptch_rt_d = {rd_data[7:0], ptch_low_q};
          state_d   = ST_RD_AL;
          wrt_d     = 1'b1;
        end
      ST_RD_AL:
        if (done) begin
          az_low_d = rd_data[7:0];
          state_d  = ST_RD_AH;
          wrt_d    = 1'b1;
        end
      ST_RD_AH:
        if (done) begin
          az_d    = {rd_data[7:0], az_low_q};
          vld_d   = 1'b1;
          state_d = ST_IDLE;
        end
      default: state_d = ST_INIT_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT_WAIT;
      tmr_q      <= '0;
      int_ff1_q  <= 1'b0;
      int_ff2_q  <= 1'b0;
      int_ff3_q  <= 1'b0;
      ptch_low_q <= '0;
      az_low_q   <= '0;
      ptch_rt_q  <= '0;
      az_q       <= '0;
      vld_q      <= 1'b0;
      wrt_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      int_ff1_q  <= INT;
      int_ff2_q  <= int_ff1_q;
      int_ff3_q  <= int_ff2_q;
      ptch_low_q <= ptch_low_d;
      az_low_q   <= az_low_d;
      ptch_rt_q  <= ptch_rt_d;
      az_q       <= az_d;
      vld_q      <= vld_d;
      wrt_q      <= wrt_d;
    end
  end

  assign vld     = vld_q;
  assign ptch_rt = ptch_rt_q;
  assign AZ      = az_q;

endmodule

// File: tb/tb_inertial_intf.sv
// Directed bench for inertial_intf with a mode-3 SPI sensor model that
// decodes MOSI frames and answers reads from a small register set.
module tb_inertial_intf;

  localparam int INIT_WAIT  = 16;
  localparam int SEQ_BUDGET = 2300;

  typedef struct {
    logic [7:0]  pl;
    logic [7:0]  ph;
    logic [7:0]  al;
    logic [7:0]  ah;
    logic [15:0] exp_ptch;
    logic [15:0] exp_az;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        INT;
  logic        MISO = 1'b0;
  logic        SS_n, SCLK, MOSI, vld;
  logic [15:0] ptch_rt, AZ;

  int checks   = 0;
  int failures = 0;

  inertial_intf #(.INIT_WAIT(INIT_WAIT), .SCLK_DIV_W(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .INT     (INT),
    .MISO    (MISO),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .vld     (vld),
    .ptch_rt (ptch_rt),
    .AZ      (AZ)
  );

  always #5 clk = ~clk;

  // Sensor model state
  logic [7:0]  s_pl = 8'h00, s_ph = 8'h00, s_al = 8'h00, s_ah = 8'h00;
  logic [7:0]  fill_byte = 8'hA5;
  logic [15:0] mosi_sr = '0;
  logic [15:0] rsp = '0;
  logic        ss_prev = 1'b1, sclk_prev = 1'b1;
  int          nrise = 0, nfall = 0, aborted = 0, vld_cnt = 0;
  logic [15:0] frames[$];

  function automatic logic [7:0] sensor_reg(input logic [7:0] a);
    case (a)
      8'hA2:   return s_pl;
      8'hA3:   return s_ph;
      8'hAC:   return s_al;
      8'hAD:   return s_ah;
      default: return 8'h00;
    endcase
  endfunction

  always @(SS_n or SCLK) begin
    if (ss_prev === 1'b1 && SS_n === 1'b0) begin
      nrise   = 0;
      nfall   = 0;
      mosi_sr = '0;
    end else if (ss_prev === 1'b0 && SS_n === 1'b1) begin
      if (nrise == 16) frames.push_back(mosi_sr);
      else if (nrise > 0) aborted++;
      nrise = 0;
    end else if (SS_n === 1'b0 && sclk_prev === 1'b1 && SCLK === 1'b0) begin
      if (nfall == 0) rsp = {fill_byte, 8'h00};
      else if (nfall == 8) rsp = {fill_byte, sensor_reg(mosi_sr[7:0])};
      if (nfall < 16) MISO = rsp[15-nfall];
      nfall++;
    end else if (SS_n === 1'b0 && sclk_prev === 1'b0 && SCLK === 1'b1) begin
      mosi_sr = {mosi_sr[14:0], MOSI};
      nrise++;
    end
    ss_prev   = SS_n;
    sclk_prev = SCLK;
  end

  always @(negedge clk) if (vld === 1'b1) vld_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_vld(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (vld !== 1'b1 && lat < SEQ_BUDGET);
    check("vld_seen", vld, 1);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int c = 0;
    while (frames.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("frames_reached", frames.size() >= n, 1);
  endtask

  task automatic wait_ss_low(input int budget);
    int c = 0;
    while (SS_n !== 1'b0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("ss_low_reached", SS_n, 0);
  endtask

  task automatic pulse_int();
    INT = 1'b1;
    repeat (4) @(negedge clk);
    INT = 1'b0;
  endtask

  task automatic check_init_gap(input string tag);
    int highs = 0;
    repeat (INIT_WAIT) begin
      @(negedge clk);
      if (SS_n === 1'b1) highs++;
    end
    check({tag, "_ss_high_cycles"}, highs, INIT_WAIT);
    @(negedge clk);
    check({tag, "_cfg0_ss_low"}, SS_n, 0);
  endtask

  task automatic check_read_frames(input string tag);
    logic [15:0] rd_exp[4];
    logic [15:0] got;
    rd_exp = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00};
    check({tag, "_frame_count"}, frames.size(), 4);
    for (int i = 0; i < 4; i++) begin
      got = (i < frames.size()) ? frames[i] : 16'hDEAD;
      check($sformatf("%s_frame%0d", tag, i), got, rd_exp[i]);
    end
  endtask

  task automatic run_read(input vec_t v, input string tag);
    int lat, vc0;
    s_pl = v.pl; s_ph = v.ph; s_al = v.al; s_ah = v.ah;
    frames.delete();
    vc0 = vld_cnt;
    pulse_int();
    wait_vld(lat);
    check({tag, "_ptch_rt"}, ptch_rt, v.exp_ptch);
    check({tag, "_AZ"}, AZ, v.exp_az);
    @(negedge clk);
    check({tag, "_vld_one_cycle"}, vld, 0);
    check({tag, "_vld_count"}, vld_cnt - vc0, 1);
    check_read_frames(tag);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[5];
    logic [15:0] cfg_exp[5];
    logic [15:0] got, held_p, held_a;
    int          lat, vc0;

    vecs[0] = '{8'h34, 8'h12, 8'h60, 8'hFF, 16'h1234, 16'hFF60};
    vecs[1] = '{8'h00, 8'h80, 8'h01, 8'h80, 16'h8000, 16'h8001};
    vecs[2] = '{8'hFF, 8'h7F, 8'hFE, 8'h7F, 16'h7FFF, 16'h7FFE};
    vecs[3] = '{8'h50, 8'h00, 8'hA0, 8'h00, 16'h0050, 16'h00A0};
    vecs[4] = '{8'h01, 8'h00, 8'hFF, 8'hFF, 16'h0001, 16'hFFFF};
    cfg_exp = '{16'h0D02, 16'h0D02, 16'h1053, 16'h1150, 16'h1460};

    rst = 1'b1;
    INT = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_SS_n", SS_n, 1);
    check("reset_SCLK", SCLK, 1);
    check("reset_MOSI", MOSI, 0);
    check("reset_vld", vld, 0);
    check("reset_ptch_rt", ptch_rt, 16'h0000);
    check("reset_AZ", AZ, 16'h0000);

    rst = 1'b0;
    check_init_gap("init1");

    // Abort CFG1 part-way through with a 3-cycle reset
    wait_frames(1, 600);
    wait_ss_low(50);
    repeat (200) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_SS_n", SS_n, 1);
    check("midrst_SCLK", SCLK, 1);
    repeat (2) @(negedge clk);
    check("midrst_vld", vld, 0);
    rst = 1'b0;
    check_init_gap("init2");
    wait_frames(5, 2400);
    for (int i = 0; i < 5; i++) begin
      got = (i < frames.size()) ? frames[i] : 16'hDEAD;
      check($sformatf("cfg_frame%0d", i), got, cfg_exp[i]);
    end
    check("cfg_aborted_frames", aborted, 1);
    repeat (100) @(negedge clk);
    check("cfg_no_extra_frames", frames.size(), 5);
    check("cfg_no_vld", vld_cnt, 0);

    for (int i = 0; i < 5; i++) run_read(vecs[i], $sformatf("vec%0d", i));

    // Second INT edge during RD_AL must be dropped
    s_pl = 8'h11; s_ph = 8'h22; s_al = 8'h33; s_ah = 8'h44;
    frames.delete();
    vc0 = vld_cnt;
    pulse_int();
    wait_frames(2, 1200);
    wait_ss_low(50);
    repeat (50) @(negedge clk);
    pulse_int();
    wait_vld(lat);
    check("drop_ptch_rt", ptch_rt, 16'h2211);
    check("drop_AZ", AZ, 16'h4433);
    repeat (2500) @(negedge clk);
    check("drop_vld_count", vld_cnt - vc0, 1);
    check("drop_frame_count", frames.size(), 4);
    run_read('{8'h55, 8'h66, 8'h77, 8'h88, 16'h6655, 16'h8877}, "after_drop");

    // INT edges at arbitrary phase relative to clk
    for (int i = 0; i < 3; i++) begin
      s_pl = 8'(i * 17 + 3);
      s_ph = 8'(8'hC0 + i);
      s_al = 8'(i * 29 + 7);
      s_ah = 8'(8'h30 + i);
      vc0 = vld_cnt;
      @(negedge clk);
      #($urandom_range(0, 9));
      INT = 1'b1;
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
        if (lat == 5) INT = 1'b0;
      end while (vld !== 1'b1 && lat < SEQ_BUDGET);
      INT = 1'b0;
      check($sformatf("rand%0d_vld_seen", i), vld, 1);
      check($sformatf("rand%0d_latency_window", i), (lat >= 3) && (lat <= 3 + 2100), 1);
      check($sformatf("rand%0d_ptch_rt", i), ptch_rt, {s_ph, s_pl});
      check($sformatf("rand%0d_AZ", i), AZ, {s_ah, s_al});
      held_p = ptch_rt;
      held_a = AZ;
      repeat (300) @(negedge clk);
      check($sformatf("rand%0d_ptch_stable", i), ptch_rt, held_p);
      check($sformatf("rand%0d_AZ_stable", i), AZ, held_a);
      check($sformatf("rand%0d_vld_count", i), vld_cnt - vc0, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
